// File: rtl/count_enable_ctrl.sv
// Enable generator for the modulo-N counter: free-run or counted bursts, one pulse every PRESCALE clocks.
// First pulse PRESCALE cycles after acceptance; burst_ready is the only handshake (low while RUN/BURST).
module count_enable_ctrl #(
  parameter int LEN_WIDTH = 4,
  parameter int PRESCALE  = 1,
  parameter int PS_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_start,
  input  logic                 run_stop,
  input  logic                 burst_req,
  input  logic [LEN_WIDTH-1:0] burst_len,
  output logic                 burst_ready,
  output logic                 enable,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] remaining
);

  typedef enum logic [1:0] {IDLE, RUN, BURST} state_t;

  localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);

  state_t               state, state_nxt;
  logic [PS_WIDTH-1:0]  ps_cnt, ps_nxt;
  logic [LEN_WIDTH-1:0] rem_nxt;
  logic                 done_nxt;
  logic                 ps_wrap;

  assign ps_wrap = (ps_cnt == PS_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ps_cnt    <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ps_cnt    <= ps_nxt;
      remaining <= rem_nxt;
      done      <= done_nxt;
    end
  end

  // ps_nxt defaults to 0 so the prescaler restarts on every entry into RUN/BURST.
  always_comb begin
    state_nxt = state;
    ps_nxt    = '0;
    rem_nxt   = remaining;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (run_start) begin
          if (!run_stop) state_nxt = RUN;
        end else if (burst_req) begin
          if (burst_len != '0) begin
            state_nxt = BURST;
            rem_nxt   = burst_len;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (run_stop) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          ps_nxt = ps_wrap ? '0 : ps_cnt + PS_WIDTH'(1);
        end
      end
      BURST: begin
        if (run_stop || (ps_wrap && remaining == LEN_WIDTH'(1))) begin
          state_nxt = IDLE;
          rem_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          ps_nxt = ps_wrap ? '0 : ps_cnt + PS_WIDTH'(1);
          if (ps_wrap) rem_nxt = remaining - LEN_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        rem_nxt   = '0;
      end
    endcase
  end

  // Outputs decode registered state only: no combinational path from inputs.
  always_comb begin
    busy        = (state == RUN) || (state == BURST);
    burst_ready = (state == IDLE);
    enable      = busy && ps_wrap;
  end

endmodule

// File: tb/tb_count_enable_ctrl.sv
// Scoreboard bench: two instances (PRESCALE 1 and 3) driven in turn; per-cycle expected outputs
// are derived from burst/run arithmetic and checked by an independent negedge monitor.
module tb_count_enable_ctrl;
  localparam int LW = 4;

  typedef struct packed {
    logic          en;
    logic          busy;
    logic          done;
    logic [LW-1:0] rem;
    logic          rdy;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         reset_v, run_start_v, run_stop_v, burst_req_v;
  logic [1:0]         burst_ready_v, enable_v, busy_v, done_v;
  logic [1:0][LW-1:0] burst_len_v, remaining_v;

  count_enable_ctrl #(.LEN_WIDTH(LW), .PRESCALE(1), .PS_WIDTH(8)) dut_p1 (
    .clk(clk), .reset(reset_v[0]), .run_start(run_start_v[0]), .run_stop(run_stop_v[0]),
    .burst_req(burst_req_v[0]), .burst_len(burst_len_v[0]), .burst_ready(burst_ready_v[0]),
    .enable(enable_v[0]), .busy(busy_v[0]), .done(done_v[0]), .remaining(remaining_v[0])
  );

  count_enable_ctrl #(.LEN_WIDTH(LW), .PRESCALE(3), .PS_WIDTH(8)) dut_p3 (
    .clk(clk), .reset(reset_v[1]), .run_start(run_start_v[1]), .run_stop(run_stop_v[1]),
    .burst_req(burst_req_v[1]), .burst_len(burst_len_v[1]), .burst_ready(burst_ready_v[1]),
    .enable(enable_v[1]), .busy(busy_v[1]), .done(done_v[1]), .remaining(remaining_v[1])
  );

  rec_t q0[$];
  rec_t q1[$];
  bit   pend[2];
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  function automatic rec_t mk(input bit en, input bit bsy, input bit dn, input int rem, input bit rdy);
    rec_t r;
    r.en   = en;
    r.busy = bsy;
    r.done = dn;
    r.rem  = LW'(rem);
    r.rdy  = rdy;
    return r;
  endfunction

  // An IDLE cycle; carries the done pulse owed by the previous operation.
  function automatic rec_t idle_rec(input int i);
    rec_t r;
    r = mk(1'b0, 1'b0, pend[i], 0, 1'b1);
    pend[i] = 1'b0;
    return r;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [LW-1:0] rl();
    return LW'($urandom_range(0, 15));
  endfunction

  function automatic int ps_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic step(input int i, input bit rs, input bit stp, input bit br,
                      input logic [LW-1:0] bl, input bit rst, input rec_t r);
    run_start_v    = '0;
    run_stop_v     = '0;
    burst_req_v    = '0;
    reset_v        = '0;
    burst_len_v    = '0;
    run_start_v[i] = rs;
    run_stop_v[i]  = stp;
    burst_req_v[i] = br;
    reset_v[i]     = rst;
    burst_len_v[i] = bl;
    if (i == 0) begin
      q0.push_back(r);
      q1.push_back(idle_rec(1));
    end else begin
      q1.push_back(r);
      q0.push_back(idle_rec(0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_idle(input int i, input int n);
    for (int c = 0; c < n; c++) step(i, 1'b0, rb(), 1'b0, rl(), 1'b0, idle_rec(i));
  endtask

  // Burst of L pulses: pulse on every P-th cycle, remaining = L minus pulses already issued.
  task automatic do_burst(input int i, input int len, input int stop_at, input int rst_at);
    int p;
    bit hit_rst;
    bit stp;
    bit rs;
    p = ps_of(i);
    hit_rst = 1'b0;
    step(i, 1'b0, 1'b0, 1'b1, LW'(len), 1'b0, idle_rec(i));
    if (len == 0) begin
      pend[i] = 1'b1;
      return;
    end
    for (int c = 0; c < len * p; c++) begin
      stp = (c == stop_at);
      rs  = (c == rst_at);
      step(i, rb(), stp, rb(), rl(), rs, mk((c % p) == p - 1, 1'b1, 1'b0, len - c / p, 1'b0));
      if (rs) begin
        hit_rst = 1'b1;
        break;
      end
      if (stp) break;
    end
    pend[i] = !hit_rst;
  endtask

  // Free run for n cycles; run_stop sampled in the last of them.
  task automatic do_run(input int i, input int n, input bit with_req);
    int p;
    p = ps_of(i);
    step(i, 1'b1, 1'b0, with_req, LW'($urandom_range(1, 15)), 1'b0, idle_rec(i));
    for (int c = 0; c < n; c++)
      step(i, rb(), (c == n - 1), rb(), rl(), 1'b0, mk((c % p) == p - 1, 1'b1, 1'b0, 0, 1'b0));
    pend[i] = 1'b1;
  endtask

  task automatic do_startstop(input int i);
    step(i, 1'b1, 1'b1, 1'b0, rl(), 1'b0, idle_rec(i));
  endtask

  task automatic check(input int i, input rec_t got);
    rec_t exp;
    bit   empty;
    empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
    checks++;
    if (empty) begin
      errors++;
      $display("FAIL scoreboard_underflow inst%0d cycle %0d: output present but no expected entry", i, cyc);
    end else begin
      if (i == 0) exp = q0.pop_front();
      else        exp = q1.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL outputs inst%0d cycle %0d: got en=%b busy=%b done=%b rem=%0d rdy=%b, expected en=%b busy=%b done=%b rem=%0d rdy=%b",
                 i, cyc, got.en, got.busy, got.done, got.rem, got.rdy,
                 exp.en, exp.busy, exp.done, exp.rem, exp.rdy);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check(0, {enable_v[0], busy_v[0], done_v[0], remaining_v[0], burst_ready_v[0]});
      check(1, {enable_v[1], busy_v[1], done_v[1], remaining_v[1], burst_ready_v[1]});
      cyc++;
    end
  end

  initial begin
    int i, op, len;
    reset_v     = 2'b11;
    run_start_v = '0;
    run_stop_v  = '0;
    burst_req_v = '0;
    burst_len_v = '0;
    pend[0]     = 1'b0;
    pend[1]     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    for (int k = 0; k < 2; k++) begin
      do_idle(k, 2);
      do_burst(k, 5, -1, -1);
      do_burst(k, 4, -1, -1);
      do_idle(k, 1);
      do_run(k, 20, 1'b0);
      do_burst(k, 3, -1, -1);
      do_idle(k, 1);
      do_burst(k, 0, -1, -1);
      do_idle(k, 2);
      do_run(k, 7, 1'b1);
      do_startstop(k);
      do_idle(k, 2);
      do_burst(k, 6, 2 * ps_of(k) + 1, -1);
      do_idle(k, 1);
      do_burst(k, 8, -1, 5 * ps_of(k));
      do_idle(k, 3);
    end

    for (int k = 0; k < 40; k++) begin
      i  = $urandom_range(0, 1);
      op = $urandom_range(0, 5);
      case (op)
        0: do_idle(i, $urandom_range(1, 3));
        1: do_burst(i, $urandom_range(0, 15), -1, -1);
        2: do_run(i, $urandom_range(1, 25), rb());
        3: begin
          len = $urandom_range(1, 15);
          do_burst(i, len, $urandom_range(0, len * ps_of(i) - 1), -1);
        end
        4: do_startstop(i);
        default: begin
          len = $urandom_range(1, 15);
          do_burst(i, len, -1, $urandom_range(0, len * ps_of(i) - 1));
        end
      endcase
    end
    do_idle(0, 3);

    mon_en = 1'b0;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
